// File: rtl/avmm_bridge_arbiter.sv
// Two-requester round-robin AVMM arbiter feeding a single AVMM-to-AXI-Lite bridge, one transaction in flight.
// Optional WAIT-state timeout is compiled in when AVMM_ARB_TIMEOUT_EN is defined.
module avmm_bridge_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [2*ADDR_WIDTH-1:0]   m_address,
  input  logic [2*DATA_WIDTH-1:0]   m_writedata,
  input  logic [2*DATA_WIDTH/8-1:0] m_byteenable,
  input  logic [1:0]                m_read,
  input  logic [1:0]                m_write,
  output logic [1:0]                m_waitrequest,
  output logic [DATA_WIDTH-1:0]     m_readdata,
  output logic [1:0]                m_readdatavalid,
  output logic [ADDR_WIDTH-1:0]     s_address,
  output logic [DATA_WIDTH-1:0]     s_writedata,
  output logic [DATA_WIDTH/8-1:0]   s_byteenable,
  output logic                      s_read,
  output logic                      s_write,
  input  logic                      s_waitrequest,
  input  logic [DATA_WIDTH-1:0]     s_readdata,
  input  logic                      s_readdatavalid,
  output logic                      timeout_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic                  s_read_q, s_read_d;
  logic                  s_write_q, s_write_d;
  logic                  wait_first_q, wait_first_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]   be_q, be_d;

  logic [1:0]            req_s;
  logic                  grant_s;
  logic                  accept_s;
  logic                  sel_write_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [BE_WIDTH-1:0]   sel_be_s;
  logic                  wait_sample_s;
  logic                  rd_done_s;
  logic                  wr_done_s;
  logic                  done_s;
  logic                  timeout_hit_s;

  // Request decode and round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    req_s = m_read | m_write;
    if (req_s == 2'b11) begin
      grant_s = ~last_q;
    end else if (req_s == 2'b10) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    accept_s = (state_q == ST_IDLE) && (req_s != 2'b00);
  end

  // Select the granted requester's command; write wins when read and write are both asserted.
  always_comb begin
    if (grant_s) begin
      sel_write_s = m_write[1];
      sel_addr_s  = m_address[2*ADDR_WIDTH-1:ADDR_WIDTH];
      sel_wdata_s = m_writedata[2*DATA_WIDTH-1:DATA_WIDTH];
      sel_be_s    = m_byteenable[2*BE_WIDTH-1:BE_WIDTH];
    end else begin
      sel_write_s = m_write[0];
      sel_addr_s  = m_address[ADDR_WIDTH-1:0];
      sel_wdata_s = m_writedata[DATA_WIDTH-1:0];
      sel_be_s    = m_byteenable[BE_WIDTH-1:0];
    end
  end

  // Completion detection; the first WAIT cycle is never sampled.
  always_comb begin
    wait_sample_s = (state_q == ST_WAIT) && !wait_first_q;
    rd_done_s     = wait_sample_s && !wr_q && s_readdatavalid;
    wr_done_s     = wait_sample_s && wr_q && !s_waitrequest;
    done_s        = rd_done_s | wr_done_s;
  end

`ifdef AVMM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PAT_REPS = (DATA_WIDTH + 31) / 32;
  localparam logic [PAT_REPS*32-1:0] PAT_WIDE = {PAT_REPS{32'hDEADBEEF}};
  localparam logic [DATA_WIDTH-1:0] TIMEOUT_DATA = PAT_WIDE[DATA_WIDTH-1:0];

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // WAIT-cycle counter, cleared whenever the FSM is outside WAIT.
  always_comb begin
    if (state_q == ST_WAIT) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
    timeout_hit_s = (state_q == ST_WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !done_s;
  end

  // WAIT-cycle counter register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // Without the timeout feature WAIT lasts until the bridge responds.
  always_comb begin
    timeout_hit_s = 1'b0;
  end
`endif

  // FSM state register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (!s_waitrequest) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_WAIT: begin
        if (done_s || timeout_hit_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs toward the requesters; read data is forwarded in the same cycle it arrives.
  always_comb begin
    m_waitrequest   = 2'b11;
    m_readdatavalid = 2'b00;
    m_readdata      = '0;
    timeout_o       = timeout_hit_s;
    if (accept_s) begin
      m_waitrequest[grant_s] = 1'b0;
    end else begin
      m_waitrequest = 2'b11;
    end
    if (rd_done_s) begin
      m_readdatavalid[owner_q] = 1'b1;
      m_readdata               = s_readdata;
    end else if (timeout_hit_s && !wr_q) begin
      m_readdatavalid[owner_q] = 1'b1;
`ifdef AVMM_ARB_TIMEOUT_EN
      m_readdata               = TIMEOUT_DATA;
`else
      m_readdata               = '0;
`endif
    end else begin
      m_readdatavalid = 2'b00;
    end
  end

  // Command capture on acceptance; s_read/s_write drop once the bridge takes the command.
  always_comb begin
    last_d       = last_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    s_read_d     = s_read_q;
    s_write_d    = s_write_q;
    wait_first_d = (state_q == ST_CMD) && !s_waitrequest;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          last_d    = grant_s;
          owner_d   = grant_s;
          wr_d      = sel_write_s;
          addr_d    = sel_addr_s;
          wdata_d   = sel_wdata_s;
          be_d      = sel_be_s;
          s_read_d  = !sel_write_s;
          s_write_d = sel_write_s;
        end else begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
        end
      end
      ST_CMD: begin
        if (!s_waitrequest) begin
          s_read_d  = 1'b0;
          s_write_d = 1'b0;
        end else begin
          s_read_d  = s_read_q;
          s_write_d = s_write_q;
        end
      end
      ST_WAIT: begin
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
      end
      default: begin
        s_read_d  = 1'b0;
        s_write_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; last_q resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      s_read_q     <= 1'b0;
      s_write_q    <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      last_q       <= last_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      s_read_q     <= s_read_d;
      s_write_q    <= s_write_d;
      wait_first_q <= wait_first_d;
    end
  end

  assign s_address    = addr_q;
  assign s_writedata  = wdata_q;
  assign s_byteenable = be_q;
  assign s_read       = s_read_q;
  assign s_write      = s_write_q;

endmodule

// File: tb/tb_avmm_bridge_arbiter.sv
// Self-checking bench for avmm_bridge_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_avmm_bridge_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int TMO = 16;

  logic              aclk = 1'b0;
  logic              areset;
  logic [2*AW-1:0]   m_address;
  logic [2*DW-1:0]   m_writedata;
  logic [2*BW-1:0]   m_byteenable;
  logic [1:0]        m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [DW-1:0]     m_readdata;
  logic [AW-1:0]     s_address;
  logic [DW-1:0]     s_writedata;
  logic [BW-1:0]     s_byteenable;
  logic              s_read, s_write, s_waitrequest, s_readdatavalid, timeout_o;
  logic [DW-1:0]     s_readdata;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          wr;
    logic          both;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
  } cmd_t;

  always #5 aclk = ~aclk;

  avmm_bridge_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .areset(areset),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .timeout_o(timeout_o)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic quiet();
    m_read = 2'b00; m_write = 2'b00; m_address = '0; m_writedata = '0; m_byteenable = '0;
    s_waitrequest = 1'b1; s_readdatavalid = 1'b0; s_readdata = '0;
  endtask

  task automatic do_reset();
    quiet();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
  endtask

  function automatic cmd_t new_cmd();
    cmd_t c;
    int kind;
    kind   = $urandom_range(0, 3);
    c.wr   = (kind >= 2);
    c.both = (kind == 3);
    c.addr = {$urandom_range(0, 255), 2'b00};
    c.data = $urandom;
    c.be   = 4'($urandom_range(0, 15));
    return c;
  endfunction

  task automatic test_reset();
    quiet();
    areset = 1'b1;
    @(negedge aclk);
    checks++; if ({s_read, s_write, m_readdatavalid, timeout_o} !== 5'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 00000", {s_read, s_write, m_readdatavalid, timeout_o}); end
    checks++; if ({s_address, s_writedata, s_byteenable} !== {(AW+DW+BW){1'b0}}) begin errors++; $display("FAIL rst_data: got %h/%h/%h want 0", s_address, s_writedata, s_byteenable); end
    step();
    areset = 1'b0;
    s_readdatavalid = 1'b1; s_readdata = 32'h55AA55AA;
    @(negedge aclk);
    checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL stray_rdv_idle: got %b want 00", m_readdatavalid); end
    checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL idle_wait: got %b want 11", m_waitrequest); end
    step();
    s_readdatavalid = 1'b0;
    m_read = 2'b11;
    @(negedge aclk);
    checks++; if (m_waitrequest !== 2'b10) begin errors++; $display("FAIL first_contention: got %b want 10", m_waitrequest); end
    step();
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    m_read = 2'b01; m_address[AW-1:0] = 32'h10;
    @(negedge aclk);
    checks++; if (m_waitrequest !== 2'b10) begin errors++; $display("FAIL sr_accept: got %b want 10", m_waitrequest); end
    step();
    m_read = 2'b00; s_waitrequest = 1'b0;
    @(negedge aclk);
    checks++; if ({s_read, s_write} !== 2'b10) begin errors++; $display("FAIL sr_cmd: got %b want 10", {s_read, s_write}); end
    checks++; if (s_address !== 32'h10) begin errors++; $display("FAIL sr_addr: got %h want 10", s_address); end
    step();
    @(negedge aclk);
    checks++; if ({s_read, m_readdatavalid} !== 3'b000) begin errors++; $display("FAIL sr_wait0: got %b want 000", {s_read, m_readdatavalid}); end
    step();
    s_readdatavalid = 1'b1; s_readdata = 32'h12345678;
    @(negedge aclk);
    checks++; if (m_readdatavalid !== 2'b01) begin errors++; $display("FAIL sr_rdv: got %b want 01", m_readdatavalid); end
    checks++; if (m_readdata !== 32'h12345678) begin errors++; $display("FAIL sr_rdata: got %h want 12345678", m_readdata); end
    step();
    s_readdatavalid = 1'b0;
    @(negedge aclk);
    checks++; if (m_readdatavalid !== 2'b00) begin errors++; $display("FAIL sr_rdv_off: got %b want 00", m_readdatavalid); end
  endtask

  task automatic test_alternating_writes();
    int grants[$];
    logic [AW-1:0] addrs[$];
    logic [DW-1:0] wdata[$];
    logic [BW-1:0] bes[$];
    int rd_seen;
    int last;
    int exp_owner;
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    logic [BW-1:0] b[2];
    a[0] = 32'h100; a[1] = 32'h200; d[0] = 32'hAAAA0000; d[1] = 32'hBBBB0001; b[0] = 4'h3; b[1] = 4'hF;
    rd_seen = 0;
    do_reset();
    s_waitrequest = 1'b0;
    m_write = 2'b11; m_address = {a[1], a[0]}; m_writedata = {d[1], d[0]}; m_byteenable = {b[1], b[0]};
    for (int c = 0; c < 40 && addrs.size() < 4; c++) begin
      @(negedge aclk);
      if (m_waitrequest !== 2'b11) grants.push_back((m_waitrequest == 2'b10) ? 0 : 1);
      if (s_write === 1'b1) begin addrs.push_back(s_address); wdata.push_back(s_writedata); bes.push_back(s_byteenable); end
      if (s_read === 1'b1) rd_seen++;
      step();
    end
    quiet();
    checks++; if (addrs.size() != 4 || grants.size() < 4) begin errors++; $display("FAIL rr_count: got %0d writes %0d grants want 4", addrs.size(), grants.size()); end
    checks++; if (rd_seen != 0) begin errors++; $display("FAIL rr_no_read: got %0d want 0", rd_seen); end
    last = 1;
    for (int k = 0; k < 4 && k < addrs.size() && k < grants.size(); k++) begin
      exp_owner = 1 - last;
      last = exp_owner;
      checks++; if (grants[k] != exp_owner) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", k, grants[k], exp_owner); end
      checks++; if ({addrs[k], wdata[k], bes[k]} !== {a[exp_owner], d[exp_owner], b[exp_owner]}) begin errors++; $display("FAIL rr_write%0d: got %h/%h/%h want %h/%h/%h", k, addrs[k], wdata[k], bes[k], a[exp_owner], d[exp_owner], b[exp_owner]); end
    end
  endtask

  task automatic test_cmd_stall();
    int stable;
    stable = 0;
    do_reset();
    m_read = 2'b10; m_address = {32'h44, 32'h0};
    @(negedge aclk);
    checks++; if (m_waitrequest !== 2'b01) begin errors++; $display("FAIL cs_accept: got %b want 01", m_waitrequest); end
    step();
    m_read = 2'b00; s_waitrequest = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      if (s_read === 1'b1 && s_address === 32'h44) stable++;
      step();
    end
    checks++; if (stable != 5) begin errors++; $display("FAIL cs_stable: got %0d want 5", stable); end
    s_waitrequest = 1'b0;
    @(negedge aclk);
    checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL cs_cycle6: got %b want 1", s_read); end
    step();
    @(negedge aclk);
    checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL cs_taken: got %b want 0", s_read); end
    step();
    s_readdatavalid = 1'b1; s_readdata = 32'hA5A55A5A;
    @(negedge aclk);
    checks++; if ({m_readdatavalid, m_readdata} !== {2'b10, 32'hA5A55A5A}) begin errors++; $display("FAIL cs_return: got %b/%h want 10/a5a55a5a", m_readdatavalid, m_readdata); end
    checks++; if (s_address !== 32'h44) begin errors++; $display("FAIL cs_addr_hold: got %h want 44", s_address); end
    step();
    quiet();
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    bad = 0;
    do_reset();
    m_read = 2'b01; m_address[AW-1:0] = 32'h88;
    @(negedge aclk);
    step();
    m_read = 2'b00; s_waitrequest = 1'b0;
    @(negedge aclk);
    step();
    #2 areset = 1'b1;
    #1;
    checks++; if ({s_read, s_write, m_readdatavalid, timeout_o} !== 5'b0) begin errors++; $display("FAIL rw_ctrl: got %b want 00000", {s_read, s_write, m_readdatavalid, timeout_o}); end
    checks++; if (s_address !== 32'h0) begin errors++; $display("FAIL rw_addr: got %h want 0", s_address); end
    step();
    areset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1'b1; s_readdata = $urandom;
      @(negedge aclk);
      if (m_readdatavalid !== 2'b00) bad++;
      step();
    end
    quiet();
    checks++; if (bad != 0) begin errors++; $display("FAIL rw_no_return: got %0d returns want 0", bad); end
  endtask

  task automatic test_read_write_same();
    do_reset();
    m_read = 2'b10; m_write = 2'b10; m_address = {32'h80, 32'h0};
    m_writedata = {32'hCAFEF00D, 32'h0}; m_byteenable = 8'hC0;
    @(negedge aclk);
    checks++; if (m_waitrequest !== 2'b01) begin errors++; $display("FAIL rw1_accept: got %b want 01", m_waitrequest); end
    step();
    m_read = 2'b00; m_write = 2'b00; s_waitrequest = 1'b0;
    @(negedge aclk);
    checks++; if ({s_write, s_read} !== 2'b10) begin errors++; $display("FAIL rw1_type: got %b want 10", {s_write, s_read}); end
    checks++; if ({s_address, s_writedata, s_byteenable} !== {32'h80, 32'hCAFEF00D, 4'hC}) begin errors++; $display("FAIL rw1_cmd: got %h/%h/%h want 80/cafef00d/c", s_address, s_writedata, s_byteenable); end
    step();
    @(negedge aclk);
    step();
    m_read = 2'b01;
    @(negedge aclk);
    checks++; if (m_waitrequest !== 2'b11) begin errors++; $display("FAIL rw1_wait1: got %b want 11", m_waitrequest); end
    step();
    @(negedge aclk);
    checks++; if (m_waitrequest !== 2'b10) begin errors++; $display("FAIL rw1_idle: got %b want 10", m_waitrequest); end
    step();
    do_reset();
  endtask

  task automatic test_wait_timeout();
    int bad;
    int limit;
    logic [DW-1:0] exp_data;
    logic exp_tmo;
    bad = 0;
    do_reset();
    m_read = 2'b10; m_address = {32'h300, 32'h0};
    @(negedge aclk);
    step();
    m_read = 2'b01; m_address[AW-1:0] = 32'h304; s_waitrequest = 1'b0;
    @(negedge aclk);
    step();
`ifdef AVMM_ARB_TIMEOUT_EN
    limit = TMO - 1; exp_data = 32'hDEADBEEF; exp_tmo = 1'b1;
`else
    limit = 39; exp_data = 32'h0BADF00D; exp_tmo = 1'b0;
`endif
    for (int w = 0; w < limit; w++) begin
      @(negedge aclk);
      if (timeout_o !== 1'b0 || m_readdatavalid !== 2'b00 || m_waitrequest !== 2'b11) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL to_hold: got %0d bad cycles want 0", bad); end
`ifndef AVMM_ARB_TIMEOUT_EN
    s_readdatavalid = 1'b1; s_readdata = 32'h0BADF00D;
`endif
    @(negedge aclk);
    checks++; if (timeout_o !== exp_tmo) begin errors++; $display("FAIL to_pulse: got %b want %b", timeout_o, exp_tmo); end
    checks++; if ({m_readdatavalid, m_readdata} !== {2'b10, exp_data}) begin errors++; $display("FAIL to_return: got %b/%h want 10/%h", m_readdatavalid, m_readdata, exp_data); end
    step();
    s_readdatavalid = 1'b0;
    @(negedge aclk);
    checks++; if ({m_waitrequest, timeout_o} !== 3'b100) begin errors++; $display("FAIL to_next_grant: got %b want 100", {m_waitrequest, timeout_o}); end
    step();
    do_reset();
  endtask

  task automatic test_random();
    cmd_t pend[2];
    cmd_t cur;
    bit [1:0] has;
    int mode, widx, owner, last, win, done_cnt;
    logic [1:0] exp_wait, exp_rdv;
    logic [DW-1:0] exp_rdata;
    logic complete, tmo;
    do_reset();
    has = 2'b00; mode = 0; widx = 0; owner = 0; last = 1; done_cnt = 0;
    cur = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!has[i] && $urandom_range(0, 3) != 0) begin pend[i] = new_cmd(); has[i] = 1'b1; end
      end
      m_read = 2'b00; m_write = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (has[i]) begin m_write[i] = pend[i].wr; m_read[i] = !pend[i].wr || pend[i].both; end
      end
      m_address = {pend[1].addr, pend[0].addr};
      m_writedata = {pend[1].data, pend[0].data};
      m_byteenable = {pend[1].be, pend[0].be};
      s_waitrequest = 1'($urandom_range(0, 1));
      s_readdatavalid = ($urandom_range(0, 2) == 0);
      s_readdata = $urandom;
      @(negedge aclk);
      win = -1;
      exp_wait = 2'b11;
      if (mode == 0 && has != 2'b00) begin
        win = (has == 2'b11) ? 1 - last : (has[1] ? 1 : 0);
        exp_wait = (win == 0) ? 2'b10 : 2'b01;
      end
      complete = 1'b0; tmo = 1'b0;
      if (mode == 2 && widx >= 1) complete = cur.wr ? !s_waitrequest : s_readdatavalid;
`ifdef AVMM_ARB_TIMEOUT_EN
      if (mode == 2 && widx == TMO - 1 && !complete) tmo = 1'b1;
`endif
      exp_rdv = 2'b00; exp_rdata = '0;
      if ((complete || tmo) && !cur.wr) begin
        exp_rdv = (owner == 0) ? 2'b01 : 2'b10;
        exp_rdata = tmo ? 32'hDEADBEEF : s_readdata;
      end
      checks++; if (m_waitrequest !== exp_wait) begin errors++; $display("FAIL rnd_grant c%0d: got %b want %b", cyc, m_waitrequest, exp_wait); end
      checks++; if ({s_read, s_write} !== {mode == 1 && !cur.wr, mode == 1 && cur.wr}) begin errors++; $display("FAIL rnd_cmd c%0d: got %b mode %0d wr %b", cyc, {s_read, s_write}, mode, cur.wr); end
      checks++; if (m_readdatavalid !== exp_rdv) begin errors++; $display("FAIL rnd_rdv c%0d: got %b want %b", cyc, m_readdatavalid, exp_rdv); end
      checks++; if (timeout_o !== tmo) begin errors++; $display("FAIL rnd_tmo c%0d: got %b want %b", cyc, timeout_o, tmo); end
      if (exp_rdv != 2'b00) begin
        checks++; if (m_readdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, m_readdata, exp_rdata); end
      end
      if (mode != 0) begin
        checks++; if (s_address !== cur.addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", cyc, s_address, cur.addr); end
      end
      if (mode == 1 && cur.wr) begin
        checks++; if ({s_writedata, s_byteenable} !== {cur.data, cur.be}) begin errors++; $display("FAIL rnd_wdata c%0d: got %h/%h want %h/%h", cyc, s_writedata, s_byteenable, cur.data, cur.be); end
      end
      case (mode)
        0: if (win >= 0) begin cur = pend[win]; owner = win; last = win; has[win] = 1'b0; mode = 1; end
        1: if (!s_waitrequest) begin mode = 2; widx = 0; end
        default: if (complete || tmo) begin mode = 0; done_cnt++; end else widx++;
      endcase
      step();
    end
    quiet();
    checks++; if (done_cnt < 20) begin errors++; $display("FAIL rnd_progress: got %0d transactions want >=20", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternating_writes();
    test_cmd_stall();
    test_reset_mid_wait();
    test_read_write_same();
    test_wait_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
